// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel addresses, syncs,
// active flag, divided pixel strobe and line/frame/animate event pulses.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CLK_DIV  = 1,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          pix_stb,
    output logic [CW-1:0] haddress,
    output logic [CW-1:0] vaddress,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic          animate
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 1 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_param_err
        $error("vga_timing_gen: CLK_DIV < 1 or CW too narrow");
    end

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_ANIM   = CW'(V_ACTIVE);
    // Bounds one bit wider so a sync ending exactly at TOTAL stays exact
    localparam logic [CW:0]   H_ACT    = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0]   H_SON    = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0]   H_SOFF   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0]   V_ACT    = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0]   V_SON    = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0]   V_SOFF   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_cnt;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          h_wrap;
    logic          v_wrap;
    logic          hs_on;
    logic          vs_on;
    logic          act_nxt;
    logic          ls_q;
    logic          fs_q;
    logic          an_q;

    assign pix_stb = enable && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (enable) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    always_comb begin
        h_wrap  = (haddress == H_LAST);
        v_wrap  = (vaddress == V_LAST);
        h_nxt   = h_wrap ? '0 : haddress + 1'b1;
        v_nxt   = vaddress;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : vaddress + 1'b1;
        end
        hs_on   = ({1'b0, h_nxt} >= H_SON) && ({1'b0, h_nxt} < H_SOFF);
        vs_on   = ({1'b0, v_nxt} >= V_SON) && ({1'b0, v_nxt} < V_SOFF);
        act_nxt = ({1'b0, h_nxt} < H_ACT) && ({1'b0, v_nxt} < V_ACT);
    end

    // Syncs and active are loaded from next-state counters so they line
    // up with the addresses they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            haddress <= '0;
            vaddress <= '0;
            hsync    <= ~H_POL;
            vsync    <= ~V_POL;
            active   <= 1'b1;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
            an_q     <= 1'b0;
        end else begin
            ls_q <= pix_stb && h_wrap;
            fs_q <= pix_stb && h_wrap && v_wrap;
            an_q <= pix_stb && h_wrap && (v_nxt == V_ANIM);
            if (pix_stb) begin
                haddress <= h_nxt;
                vaddress <= v_nxt;
                hsync    <= hs_on ? H_POL : ~H_POL;
                vsync    <= vs_on ? V_POL : ~V_POL;
                active   <= act_nxt;
            end
        end
    end

    assign line_start  = ls_q & enable;
    assign frame_start = fs_q & enable;
    assign animate     = an_q & enable;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance and a small
// divided instance, both checked every cycle against a pixel-count model.
module tb_vga_timing_gen;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        int hpol; int vpol; int div;
    } cfg_t;

    typedef struct packed {
        int stb; int h; int v; int hs; int vs;
        int act; int ls; int fs; int an;
    } out_t;

    typedef struct {
        bit en; int stb; int h; int v; int hs; int act;
    } vec_t;

    localparam cfg_t CA = '{ha:640, hf:16, hs:96, hb:48,
                            va:480, vf:10, vs:2, vb:33,
                            hpol:0, vpol:0, div:1};
    localparam cfg_t CB = '{ha:8, hf:2, hs:3, hb:3,
                            va:4, vf:1, vs:1, vb:2,
                            hpol:1, vpol:1, div:4};

    logic clk = 1'b0;
    logic rst;
    logic en;

    logic       a_stb, a_hs, a_vs, a_act, a_ls, a_fs, a_an;
    logic [9:0] a_h, a_v;
    logic       b_stb, b_hs, b_vs, b_act, b_ls, b_fs, b_an;
    logic [3:0] b_h, b_v;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    int pA = 0, phA = 0;
    int pB = 0, phB = 0;
    bit advA = 1'b0, advB = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .clk(clk), .reset(rst), .enable(en), .pix_stb(a_stb),
        .haddress(a_h), .vaddress(a_v), .hsync(a_hs), .vsync(a_vs),
        .active(a_act), .line_start(a_ls), .frame_start(a_fs),
        .animate(a_an)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(4), .CW(4)
    ) u_b (
        .clk(clk), .reset(rst), .enable(en), .pix_stb(b_stb),
        .haddress(b_h), .vaddress(b_v), .hsync(b_hs), .vsync(b_vs),
        .active(b_act), .line_start(b_ls), .frame_start(b_fs),
        .animate(b_an)
    );

    task automatic cmp(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Position is just the count of strobes taken since reset
    function automatic out_t model(cfg_t c, int p, int ph, bit adv, bit e);
        out_t o;
        int ht, vt, h, v, s0, v0;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        h  = p % ht;
        v  = (p / ht) % vt;
        s0 = c.ha + c.hf;
        v0 = c.va + c.vf;
        o.stb = int'(e && ph == c.div - 1);
        o.h   = h;
        o.v   = v;
        o.hs  = (h >= s0 && h < s0 + c.hs) ? c.hpol : 1 - c.hpol;
        o.vs  = (v >= v0 && v < v0 + c.vs) ? c.vpol : 1 - c.vpol;
        o.act = int'(h < c.ha && v < c.va);
        o.ls  = int'(e && adv && h == 0);
        o.fs  = int'(e && adv && h == 0 && v == 0);
        o.an  = int'(e && adv && h == 0 && v == c.va);
        return o;
    endfunction

    task automatic check_set(input string t, input out_t g, input out_t x);
        cmp({t, "_stb"}, g.stb, x.stb);
        cmp({t, "_haddr"}, g.h, x.h);
        cmp({t, "_vaddr"}, g.v, x.v);
        cmp({t, "_hsync"}, g.hs, x.hs);
        cmp({t, "_vsync"}, g.vs, x.vs);
        cmp({t, "_active"}, g.act, x.act);
        cmp({t, "_line_start"}, g.ls, x.ls);
        cmp({t, "_frame_start"}, g.fs, x.fs);
        cmp({t, "_animate"}, g.an, x.an);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pA <= 0; phA <= 0; advA <= 1'b0;
            pB <= 0; phB <= 0; advB <= 1'b0;
        end else begin
            advA <= en && (phA == CA.div - 1);
            advB <= en && (phB == CB.div - 1);
            if (en) begin
                if (phA == CA.div - 1) begin
                    phA <= 0; pA <= pA + 1;
                end else begin
                    phA <= phA + 1;
                end
                if (phB == CB.div - 1) begin
                    phB <= 0; pB <= pB + 1;
                end else begin
                    phB <= phB + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            out_t g;
            g = '{stb:int'(a_stb), h:int'(a_h), v:int'(a_v),
                  hs:int'(a_hs), vs:int'(a_vs), act:int'(a_act),
                  ls:int'(a_ls), fs:int'(a_fs), an:int'(a_an)};
            check_set("a", g, model(CA, pA, phA, advA, en));
            g = '{stb:int'(b_stb), h:int'(b_h), v:int'(b_v),
                  hs:int'(b_hs), vs:int'(b_vs), act:int'(b_act),
                  ls:int'(b_ls), fs:int'(b_fs), an:int'(b_an)};
            check_set("b", g, model(CB, pB, phB, advB, en));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[11];
        int la1, la2, fb1, fb2, ab1, nact, hmax, vmax, n;
        bit found;

        tbl[0]  = '{1'b1, 0, 0, 0, 0, 1};
        tbl[1]  = '{1'b1, 0, 0, 0, 0, 1};
        tbl[2]  = '{1'b1, 0, 0, 0, 0, 1};
        tbl[3]  = '{1'b1, 1, 0, 0, 0, 1};
        tbl[4]  = '{1'b1, 0, 1, 0, 0, 1};
        tbl[5]  = '{1'b0, 0, 1, 0, 0, 1};
        tbl[6]  = '{1'b0, 0, 1, 0, 0, 1};
        tbl[7]  = '{1'b1, 0, 1, 0, 0, 1};
        tbl[8]  = '{1'b1, 0, 1, 0, 0, 1};
        tbl[9]  = '{1'b1, 1, 1, 0, 0, 1};
        tbl[10] = '{1'b1, 0, 2, 0, 0, 1};

        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        cmp("rst_a_h", int'(a_h), 0);
        cmp("rst_a_v", int'(a_v), 0);
        cmp("rst_a_hsync", int'(a_hs), 1);
        cmp("rst_a_vsync", int'(a_vs), 1);
        cmp("rst_b_hsync", int'(b_hs), 0);
        cmp("rst_b_vsync", int'(b_vs), 0);
        cmp("rst_a_active", int'(a_act), 1);
        cmp("rst_a_stb_en0", int'(a_stb), 0);
        cmp("rst_a_pulses", int'({a_ls, a_fs, a_an}), 0);
        chk_on = 1'b1;

        step();
        en = 1'b1;
        @(negedge clk);
        cmp("rst_a_stb_en1", int'(a_stb), 1);
        cmp("rst_b_stb_en1", int'(b_stb), 0);
        step();
        rst = 1'b0;

        // Divider phase and enable freeze on the divided instance
        for (int i = 0; i < 11; i++) begin
            en = tbl[i].en;
            @(negedge clk);
            cmp($sformatf("vec%0d_stb", i), int'(b_stb), tbl[i].stb);
            cmp($sformatf("vec%0d_h", i), int'(b_h), tbl[i].h);
            cmp($sformatf("vec%0d_v", i), int'(b_v), tbl[i].v);
            cmp($sformatf("vec%0d_hsync", i), int'(b_hs), tbl[i].hs);
            cmp($sformatf("vec%0d_active", i), int'(b_act), tbl[i].act);
            step();
        end

        // Event spacing from a fresh reset
        #2 rst = 1'b1;
        step();
        rst = 1'b0;
        en  = 1'b1;
        la1 = -1; la2 = -1; fb1 = -1; fb2 = -1; ab1 = -1;
        nact = 0; hmax = 0; vmax = 0;
        for (n = 1; n <= 1700; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_ls) begin
                if (la1 < 0) la1 = n;
                else if (la2 < 0) la2 = n;
            end
            if (b_fs) begin
                cmp("b_line_with_frame", int'(b_ls), 1);
                if (fb1 < 0) fb1 = n;
                else if (fb2 < 0) fb2 = n;
            end
            if (b_an && ab1 < 0) ab1 = n;
            if (n < 512) begin
                if (b_stb && b_act) nact++;
                if (int'(b_h) > hmax) hmax = int'(b_h);
                if (int'(b_v) > vmax) vmax = int'(b_v);
            end
        end
        cmp("a_first_line_start", la1, 800);
        cmp("a_line_period", la2 - la1, 800);
        cmp("b_first_frame_start", fb1, 512);
        cmp("b_frame_period", fb2 - fb1, 512);
        cmp("b_first_animate", ab1, 256);
        cmp("b_active_pixels", nact, 32);
        cmp("b_hmax", hmax, 15);
        cmp("b_vmax", vmax, 7);

        // Freeze at haddress 300 for 37 clocks
        step();
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (a_h == 10'd300) found = 1'b1;
            else step();
        end
        cmp("a_reach_300", int'(found), 1);
        en = 1'b0;
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            cmp("hold_h", int'(a_h), 300);
            cmp("hold_stb", int'(a_stb), 0);
            cmp("hold_hsync", int'(a_hs), 1);
            cmp("hold_pulses", int'({a_ls, a_fs, a_an, b_ls}), 0);
            step();
        end
        en = 1'b1;
        @(negedge clk);
        cmp("resume_h_before", int'(a_h), 300);
        step();
        cmp("resume_h_after", int'(a_h), 301);

        // Asynchronous reset mid-frame on the divided instance
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (b_v == 4'd5 && b_h == 4'd6) found = 1'b1;
            else step();
        end
        cmp("b_reach_mid", int'(found), 1);
        #2 rst = 1'b1;
        #1;
        cmp("arst_b_h", int'(b_h), 0);
        cmp("arst_b_v", int'(b_v), 0);
        cmp("arst_b_vsync", int'(b_vs), 0);
        cmp("arst_b_active", int'(b_act), 1);
        cmp("arst_b_stb", int'(b_stb), 0);
        cmp("arst_a_stb", int'(a_stb), 1);
        step();
        rst = 1'b0;
        fb1 = -1;
        for (n = 1; n <= 700 && fb1 < 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (b_fs) fb1 = n;
        end
        cmp("arst_first_frame", fb1, 512);

        // Random enable with rare asynchronous resets
        step();
        for (int i = 0; i < 5000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 799) == 0) begin
                #($urandom_range(1, 3)) rst = 1'b1;
            end
            step();
            rst = 1'b0;
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: next generation of the fixed 640x480 sync/address counter used by the dino game display path. Produces horizontal/vertical pixel addresses, sync pulses with programmable polarity, a display-active flag, a pixel strobe from an integer clock divider, and single-cycle line/frame/animate event pulses for the game-logic objects. Sits between the board clock and the pixel colour mux; every sprite/object block keys off its addresses and `animate`.

## Interface

- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch (pixels)
- H_SYNC, 96: hsync width (pixels)
- H_BP, 48: horizontal back porch (pixels)
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch (lines)
- V_SYNC, 2: vsync width (lines)
- V_BP, 33: vertical back porch (lines)
- H_POL, 0: hsync asserted level (0 = active-low)
- V_POL, 0: vsync asserted level
- CLK_DIV, 1: clk cycles per pixel, >= 1
- CW, 10: address counter width; must hold H_TOTAL-1 and V_TOTAL-1
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run when high; freeze all counters when low
- pix_stb  out  1  high for the clk cycle at whose end counters advance
- haddress  out  CW  horizontal position, 0..H_TOTAL-1
- vaddress  out  CW  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per H_POL
- vsync  out  1  vertical sync, level per V_POL
- active  out  1  haddress < H_ACTIVE and vaddress < V_ACTIVE
- line_start  out  1  1-clk pulse: haddress just wrapped to 0
- frame_start  out  1  1-clk pulse: (haddress, vaddress) just wrapped to (0,0)
- animate  out  1  1-clk pulse: position just became (0, V_ACTIVE) (start of vertical blank)

## Operation

- Divider div_cnt counts 0..CLK_DIV-1 while enable high, holds while low. pix_stb = enable && div_cnt == CLK_DIV-1 (combinational). CLK_DIV = 1: pix_stb = enable.
- On each clk edge with pix_stb high: haddress increments; at H_TOTAL-1 it wraps to 0 and vaddress increments; vaddress at V_TOTAL-1 wraps to 0. Counters never hold a value >= TOTAL.
- hsync = H_POL when haddress in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~H_POL. vsync likewise on vaddress with V_* parameters.
- hsync, vsync, active registered, computed from next-state counters, so each is consistent with haddress/vaddress in the same cycle.
- line_start/frame_start/animate registered; high exactly the one clk cycle following the advancing edge that produced the named position; low otherwise, low while enable low.
- enable low: every output holds except pix_stb and pulses, which are 0.
- Elaboration error if CLK_DIV < 1 or CW cannot represent H_TOTAL-1 or V_TOTAL-1.

## Timing

- Reset values: haddress 0, vaddress 0, div_cnt 0, hsync ~H_POL, vsync ~V_POL, active 1, pix_stb per formula, line_start/frame_start/animate 0.
- Reset mid-frame: immediate return to reset values; no pulses emitted by the reset itself. First advance CLK_DIV clk edges after release with enable high.
- Line period H_TOTAL*CLK_DIV clk; frame period H_TOTAL*V_TOTAL*CLK_DIV clk.
- Simultaneous end of line and frame: line_start and frame_start both pulse in the same cycle.
- Output latency from counter to sync/active: zero cycles (aligned).

## Test plan

- Defaults, enable=1: hsync low exactly for haddress 656..751, period 800 clk; vsync low for vaddress 490..491; frame_start every 420000 clk; animate once per frame at (0,480).
- CLK_DIV=4: pix_stb high 1 of every 4 clk; haddress step every 4 clk; frame_start every 1680000 clk.
- Small params H 8/2/3/3, V 4/1/1/2, H_POL=V_POL=1: hsync high at haddress 10..12, vsync high at vaddress 5, active count 32 per 128-pixel frame, haddress max 15, vaddress max 7.
- enable low for 37 clk at haddress 300: counters/syncs hold, pix_stb and pulses 0; resume advances to 301 on next strobe.
- reset asserted at (500, 200) asynchronously between edges: outputs go to reset values before next edge; after release counting restarts from (0,0), first frame_start after full frame period.
